card_shoe: RTL and testbench

CARD_SHOE -- requirements
Module: card_shoe

---
 rtl/card_shoe_if.sv | 29 ++
 rtl/card_shoe.sv | 130 +++++++++++++
 tb/tb_card_shoe.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_shoe_if.sv
// card_shoe_if: groups the card_shoe request and status signals.
//   draw       : level draw request, each rising edge asks for one card
//   shuffle    : synchronous refill request
//   card       : last dealt rank, 1..13
//   card_valid : one-cycle pulse when card takes a new value
//   cards_left : undealt cards, 0..52
//   empty      : cards_left == 0
//   busy       : deal FSM not idle
//   deal_err   : one-cycle pulse when a draw is refused
interface card_shoe_if;
    logic       draw;
    logic       shuffle;
    logic [3:0] card;
    logic       card_valid;
    logic [5:0] cards_left;
    logic       empty;
    logic       busy;
    logic       deal_err;

    modport master (
        output draw, shuffle,
        input  card, card_valid, cards_left, empty, busy, deal_err
    );

    modport slave (
        input  draw, shuffle,
        output card, card_valid, cards_left, empty, busy, deal_err
    );
endinterface

// File: rtl/card_shoe.sv
// card_shoe: 52-card shoe dealing random ranks without replacement.
// Ports:
//   clock  : single rising-edge clock
//   resetn : asynchronous active-low reset, released synchronously
//   bus    : card_shoe_if slave modport (draw/shuffle in, card/status out)
// Parameter:
//   SEED   : LFSR reset value (0 is replaced by 16'h0001)
// Build option:
//   CARD_SHOE_AUTO_RESHUFFLE_EN : a draw on an empty shoe refills it and
//   deals normally instead of pulsing deal_err.
module card_shoe #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        resetn,
    card_shoe_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PICK, SEARCH, DEAL} state_t;

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic        rst_sync_q;
    state_t      state_q, state_d;
    logic [15:0] lfsr_q;
    logic        draw_q;
    logic [3:0]  cand_q, cand_d;
    logic [2:0]  cnt_q [13];
    logic [2:0]  cnt_d [13];
    logic [5:0]  left_q, left_d;
    logic [3:0]  card_q, card_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        draw_edge;
    logic [3:0]  cand_idx;

    // Reset asserts immediately but releases on a clock edge, so the
    // first draw edge can only be registered on the second clock.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) rst_sync_q <= 1'b0;
        else         rst_sync_q <= 1'b1;
    end

    assign draw_edge = bus.draw & ~draw_q;
    assign cand_idx  = cand_q - 4'd1;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        card_d  = card_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (bus.shuffle) begin
            // Refill wins over everything, including a same-cycle draw edge.
            for (int unsigned i = 0; i < 13; i++) cnt_d[i] = 3'd4;
            left_d  = 6'd52;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (draw_edge) begin
                        if (left_q != 6'd0) begin
                            state_d = PICK;
                        end else begin
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
                            for (int unsigned i = 0; i < 13; i++) cnt_d[i] = 3'd4;
                            left_d  = 6'd52;
                            state_d = PICK;
`else
                            err_d = 1'b1;
`endif
                        end
                    end
                end
                PICK: begin
                    cand_d  = 4'((lfsr_q[7:0] % 8'd13) + 8'd1);
                    state_d = SEARCH;
                end
                SEARCH: begin
                    // Linear probe from the random start; a non-empty shoe
                    // guarantees a hit within 13 steps.
                    if (cnt_q[cand_idx] != 3'd0) state_d = DEAL;
                    else cand_d = (cand_q == 4'd13) ? 4'd1 : cand_q + 4'd1;
                end
                DEAL: begin
                    cnt_d[cand_idx] = cnt_q[cand_idx] - 3'd1;
                    left_d  = left_q - 6'd1;
                    card_d  = cand_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            draw_q  <= 1'b0;
            cand_q  <= 4'd1;
            for (int unsigned i = 0; i < 13; i++) cnt_q[i] <= 3'd4;
            left_q  <= 6'd52;
            card_q  <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            draw_q  <= bus.draw;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            card_q  <= card_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.card       = card_q;
    assign bus.card_valid = valid_q;
    assign bus.cards_left = left_q;
    assign bus.empty      = (left_q == 6'd0);
    assign bus.busy       = (state_q != IDLE);
    assign bus.deal_err   = err_q;

endmodule

// File: tb/tb_card_shoe.sv
module tb_card_shoe;

    logic clock;
    logic resetn;

    card_shoe_if bus ();
    card_shoe_if bus0 ();
    card_shoe_if bus1 ();

    card_shoe dut (.clock(clock), .resetn(resetn), .bus(bus));
    card_shoe #(.SEED(16'h0000)) dut_s0 (.clock(clock), .resetn(resetn), .bus(bus0));
    card_shoe #(.SEED(16'h0001)) dut_s1 (.clock(clock), .resetn(resetn), .bus(bus1));

    assign bus0.draw    = bus.draw;
    assign bus0.shuffle = bus.shuffle;
    assign bus1.draw    = bus.draw;
    assign bus1.shuffle = bus.shuffle;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];

    always @(negedge clock) begin
        if (bus0.card_valid) q0.push_back(bus0.card);
        if (bus1.card_valid) q1.push_back(bus1.card);
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One draw pulse, observed for a bounded window.
    task automatic do_draw(output int nvalid, output int nerr,
                           output int last_card, output int lat);
        nvalid = 0; nerr = 0; last_card = -1; lat = -1;
        @(negedge clock);
        bus.draw = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (bus.card_valid) begin
                nvalid++;
                last_card = int'(bus.card);
                if (lat < 0) lat = c - 1;
            end
            if (bus.deal_err) nerr++;
        end
        bus.draw = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_shuffle();
        @(negedge clock);
        bus.shuffle = 1'b1;
        @(negedge clock);
        bus.shuffle = 1'b0;
        @(negedge clock);
    endtask

    typedef struct {
        int op;          // 0 = draw, 1 = shuffle
        int exp_valid;
        int exp_err;
        int exp_left;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int nv, ne, cd, lat;
        int tally[14];
        int old_card;
        bit rng_ok;

        vecs[0] = '{0, 1, 0, 50};
        vecs[1] = '{0, 1, 0, 49};
        vecs[2] = '{1, 0, 0, 52};
        vecs[3] = '{0, 1, 0, 51};
        vecs[4] = '{1, 0, 0, 52};

        resetn      = 1'b0;
        bus.draw    = 1'b0;
        bus.shuffle = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_card",  int'(bus.card), 0);
        check("rst_valid", int'(bus.card_valid), 0);
        check("rst_left",  int'(bus.cards_left), 52);
        check("rst_empty", int'(bus.empty), 0);
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_err",   int'(bus.deal_err), 0);

        // Release reset with draw already high: accepted on the second clock.
        resetn   = 1'b1;
        bus.draw = 1'b1;
        @(negedge clock);
        check("rel_busy_1st", int'(bus.busy), 0);
        @(negedge clock);
        check("rel_busy_2nd", int'(bus.busy), 1);
        nv = 0; lat = -1; cd = -1;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clock);
            if (bus.card_valid) begin
                nv++;
                cd = int'(bus.card);
                if (lat < 0) lat = c - 1;
            end
        end
        bus.draw = 1'b0;
        @(negedge clock);
        check("rel_nvalid", nv, 1);
        check("rel_lat_ok", int'(lat >= 3 && lat <= 15), 1);
        check("rel_card_ok", int'(cd >= 1 && cd <= 13), 1);
        check("rel_left", int'(bus.cards_left), 51);
        check("rel_busy_after", int'(bus.busy), 0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].op == 0) do_draw(nv, ne, cd, lat);
            else begin
                do_shuffle();
                nv = 0; ne = 0;
            end
            check($sformatf("vec%0d_valid", i), nv, vecs[i].exp_valid);
            check($sformatf("vec%0d_err", i), ne, vecs[i].exp_err);
            check($sformatf("vec%0d_left", i), int'(bus.cards_left), vecs[i].exp_left);
            check($sformatf("vec%0d_empty", i), int'(bus.empty), int'(vecs[i].exp_left == 0));
            check($sformatf("vec%0d_busy", i), int'(bus.busy), 0);
        end

        // Full deck from a freshly filled shoe.
        for (int r = 0; r < 14; r++) tally[r] = 0;
        rng_ok = 1'b1;
        for (int d = 0; d < 52; d++) begin
            do_draw(nv, ne, cd, lat);
            check($sformatf("deck%0d_valid", d), nv, 1);
            check($sformatf("deck%0d_lat_ok", d), int'(lat >= 3 && lat <= 15), 1);
            if (cd >= 1 && cd <= 13) tally[cd]++;
            else rng_ok = 1'b0;
        end
        check("deck_card_range", int'(rng_ok), 1);
        for (int r = 1; r <= 13; r++) check($sformatf("deck_rank%0d", r), tally[r], 4);
        check("deck_left", int'(bus.cards_left), 0);
        check("deck_empty", int'(bus.empty), 1);

        // Draw on an empty shoe.
        do_draw(nv, ne, cd, lat);
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
        check("empty_valid", nv, 1);
        check("empty_err", ne, 0);
        check("empty_left", int'(bus.cards_left), 51);
`else
        check("empty_valid", nv, 0);
        check("empty_err", ne, 1);
        check("empty_left", int'(bus.cards_left), 0);
        repeat (5) @(negedge clock);
        check("empty_left_hold", int'(bus.cards_left), 0);
`endif

        // Shuffle abort in SEARCH with 40 cards left.
        do_shuffle();
        for (int d = 0; d < 12; d++) do_draw(nv, ne, cd, lat);
        check("abort_pre_left", int'(bus.cards_left), 40);
        old_card = int'(bus.card);
        @(negedge clock);
        bus.draw = 1'b1;
        @(negedge clock);
        check("abort_pick_busy", int'(bus.busy), 1);
        @(negedge clock);
        bus.shuffle = 1'b1;
        @(negedge clock);
        bus.shuffle = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_left", int'(bus.cards_left), 52);
        check("abort_card", int'(bus.card), old_card);
        nv = int'(bus.card_valid);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.card_valid) nv++;
        end
        bus.draw = 1'b0;
        @(negedge clock);
        check("abort_nvalid", nv, 0);

        // Shuffle and draw edge in the same cycle.
        do_draw(nv, ne, cd, lat);
        check("coll_pre_left", int'(bus.cards_left), 51);
        @(negedge clock);
        bus.draw    = 1'b1;
        bus.shuffle = 1'b1;
        @(negedge clock);
        bus.shuffle = 1'b0;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.card_valid) nv++;
        end
        bus.draw = 1'b0;
        @(negedge clock);
        check("coll_nvalid", nv, 0);
        check("coll_left", int'(bus.cards_left), 52);
        check("coll_busy", int'(bus.busy), 0);

        // Second draw edge while busy is dropped.
        @(negedge clock);
        bus.draw = 1'b1;
        @(negedge clock);
        bus.draw = 1'b0;
        nv = int'(bus.card_valid);
        @(negedge clock);
        bus.draw = 1'b1;
        if (bus.card_valid) nv++;
        for (int c = 0; c < 25; c++) begin
            @(negedge clock);
            if (bus.card_valid) nv++;
        end
        bus.draw = 1'b0;
        @(negedge clock);
        check("busy_nvalid", nv, 1);
        check("busy_left", int'(bus.cards_left), 51);
        check("busy_idle", int'(bus.busy), 0);

        // Asynchronous reset in SEARCH.
        @(negedge clock);
        bus.draw = 1'b1;
        @(negedge clock);
        @(negedge clock);
        resetn   = 1'b0;
        bus.draw = 1'b0;
        #1;
        check("arst_card",  int'(bus.card), 0);
        check("arst_valid", int'(bus.card_valid), 0);
        check("arst_left",  int'(bus.cards_left), 52);
        check("arst_empty", int'(bus.empty), 0);
        check("arst_busy",  int'(bus.busy), 0);
        check("arst_err",   int'(bus.deal_err), 0);
        @(negedge clock);
        resetn = 1'b1;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.card_valid) nv++;
        end
        check("arst_nvalid", nv, 0);

        // SEED of zero must behave exactly like SEED of one.
        for (int d = 0; d < 3; d++) do_draw(nv, ne, cd, lat);
        check("seed0_count", q0.size(), q1.size());
        check("seed0_enough", int'(q1.size() >= 60), 1);
        for (int i = 0; i < q0.size() && i < q1.size(); i++)
            check($sformatf("seed0_card%0d", i), int'(q0[i]), int'(q1[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
